// File: rtl/vend_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : vend_ctrl_if
// Brief    : Pulse inputs and display/actuator outputs of the vending controller.
// Revision : 1.0
// =============================================================================
interface vend_ctrl_if;
    logic       coin1_p;
    logic       coin5_p;
    logic       coin10_p;
    logic       sel_p;
    logic       buy_p;
    logic       cancel_p;
    logic       restock_p;
    logic [7:0] credit;
    logic [1:0] sel_idx;
    logic [7:0] price;
    logic       sold_out;
    logic       dispense;
    logic [1:0] disp_idx;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       coin_reject;
    logic       buy_fail;
    logic       busy;

    modport master (
        output coin1_p, coin5_p, coin10_p, sel_p, buy_p, cancel_p, restock_p,
        input  credit, sel_idx, price, sold_out, dispense, disp_idx,
               change_valid, change_amt, coin_reject, buy_fail, busy
    );

    modport slave (
        input  coin1_p, coin5_p, coin10_p, sel_p, buy_p, cancel_p, restock_p,
        output credit, sel_idx, price, sold_out, dispense, disp_idx,
               change_valid, change_amt, coin_reject, buy_fail, busy
    );
endinterface
`default_nettype wire

// File: rtl/vend_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : vend_ctrl
// Brief    : Vending transaction controller: credit, selection, stock, dispense
//            and change-return sequencing driven by one-cycle input pulses.
// Revision : 1.0
// =============================================================================
module vend_ctrl #(
    parameter logic [7:0]  PRICE0      = 8'd3,
    parameter logic [7:0]  PRICE1      = 8'd5,
    parameter logic [7:0]  PRICE2      = 8'd8,
    parameter logic [7:0]  PRICE3      = 8'd10,
    parameter logic [7:0]  MAX_CREDIT  = 8'd99,
    parameter logic [3:0]  STOCK_INIT  = 4'd5,
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned TIMEOUT     = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    vend_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_REFUND = 2'd3
    } state_t;

    localparam logic [15:0] C_HOLD_LAST    = 16'(HOLD_CYCLES - 1);
    localparam logic [20:0] C_TIMEOUT_LAST = 21'(TIMEOUT - 1);

    state_t      r_state,        w_state_nx;
    logic [7:0]  r_credit,       w_credit_nx;
    logic [1:0]  r_sel,          w_sel_nx;
    logic [3:0]  r_stock [4];
    logic [3:0]  w_stock_nx [4];
    logic [20:0] r_timer,        w_timer_nx;
    logic [15:0] r_hold,         w_hold_nx;
    logic [1:0]  r_disp_idx,     w_disp_idx_nx;
    logic [7:0]  r_change_amt,   w_change_amt_nx;
    logic        r_coin_reject,  w_coin_reject_nx;
    logic        r_buy_fail,     w_buy_fail_nx;

    logic        w_any_coin;
    logic        w_any_pulse;
    logic [4:0]  w_coin_sum;
    logic [8:0]  w_credit_sum;
    logic [7:0]  w_price;
    logic        w_sold_out;
    logic        w_refund;

    assign w_any_coin   = bus.coin1_p | bus.coin5_p | bus.coin10_p;
    assign w_any_pulse  = w_any_coin | bus.sel_p | bus.buy_p | bus.cancel_p | bus.restock_p;
    assign w_coin_sum   = (bus.coin1_p  ? 5'd1  : 5'd0)
                        + (bus.coin5_p  ? 5'd5  : 5'd0)
                        + (bus.coin10_p ? 5'd10 : 5'd0);
    assign w_credit_sum = {1'b0, r_credit} + {4'b0000, w_coin_sum};
    assign w_sold_out   = (r_stock[r_sel] == 4'd0);

    always_comb begin
        case (r_sel)
            2'd0:    w_price = PRICE0;
            2'd1:    w_price = PRICE1;
            2'd2:    w_price = PRICE2;
            default: w_price = PRICE3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_sel         <= '0;
            for (int i = 0; i < 4; i++) r_stock[i] <= STOCK_INIT;
            r_timer       <= '0;
            r_hold        <= '0;
            r_disp_idx    <= '0;
            r_change_amt  <= '0;
            r_coin_reject <= 1'b0;
            r_buy_fail    <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_credit      <= w_credit_nx;
            r_sel         <= w_sel_nx;
            r_stock       <= w_stock_nx;
            r_timer       <= w_timer_nx;
            r_hold        <= w_hold_nx;
            r_disp_idx    <= w_disp_idx_nx;
            r_change_amt  <= w_change_amt_nx;
            r_coin_reject <= w_coin_reject_nx;
            r_buy_fail    <= w_buy_fail_nx;
        end
    end

    always_comb begin
        w_state_nx       = r_state;
        w_credit_nx      = r_credit;
        w_sel_nx         = r_sel;
        w_stock_nx       = r_stock;
        w_timer_nx       = '0;
        w_hold_nx        = '0;
        w_disp_idx_nx    = r_disp_idx;
        w_change_amt_nx  = r_change_amt;
        w_coin_reject_nx = 1'b0;
        w_buy_fail_nx    = 1'b0;
        w_refund         = 1'b0;

        case (r_state)
            S_IDLE, S_CREDIT: begin
                // Idle cycles in CREDIT run the refund timer; any pulse restarts it.
                if (r_state == S_CREDIT && !w_any_pulse) begin
                    if (r_timer == C_TIMEOUT_LAST) w_refund = 1'b1;
                    else                           w_timer_nx = r_timer + 21'd1;
                end else if (bus.cancel_p) begin
                    w_coin_reject_nx = w_any_coin;
                    w_refund         = (r_state == S_CREDIT);
                end else if (bus.buy_p) begin
                    w_coin_reject_nx = w_any_coin;
                    if (r_state == S_IDLE || w_sold_out || r_credit < w_price) begin
                        w_buy_fail_nx = 1'b1;
                    end else begin
                        w_stock_nx[r_sel] = r_stock[r_sel] - 4'd1;
                        w_disp_idx_nx     = r_sel;
                        w_credit_nx       = r_credit - w_price;
                        w_state_nx        = S_VEND;
                    end
                end else if (w_any_coin) begin
                    if (w_credit_sum <= {1'b0, MAX_CREDIT}) begin
                        w_credit_nx = w_credit_sum[7:0];
                        w_state_nx  = S_CREDIT;
                    end else begin
                        w_coin_reject_nx = 1'b1;
                    end
                end else if (bus.sel_p) begin
                    w_sel_nx = r_sel + 2'd1;
                end else if (bus.restock_p && r_state == S_IDLE) begin
                    for (int i = 0; i < 4; i++) w_stock_nx[i] = STOCK_INIT;
                end
            end
            default: begin
                w_coin_reject_nx = w_any_coin;
                w_buy_fail_nx    = bus.buy_p;
                if (r_hold == C_HOLD_LAST) begin
                    if (r_state == S_REFUND) begin
                        w_change_amt_nx = '0;
                        w_state_nx      = S_IDLE;
                    end else if (r_credit != 8'd0) begin
                        w_refund = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_hold_nx = r_hold + 16'd1;
                end
            end
        endcase

        if (w_refund) begin
            w_change_amt_nx = r_credit;
            w_credit_nx     = '0;
            w_state_nx      = S_REFUND;
        end
    end

    assign bus.credit       = r_credit;
    assign bus.sel_idx      = r_sel;
    assign bus.price        = w_price;
    assign bus.sold_out     = w_sold_out;
    assign bus.dispense     = (r_state == S_VEND);
    assign bus.disp_idx     = r_disp_idx;
    assign bus.change_valid = (r_state == S_REFUND);
    assign bus.change_amt   = r_change_amt;
    assign bus.coin_reject  = r_coin_reject;
    assign bus.buy_fail     = r_buy_fail;
    assign bus.busy         = (r_state == S_VEND) || (r_state == S_REFUND);
endmodule
`default_nettype wire

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Transaction controller for the vending machine. It consumes the single-cycle, debounced rising-edge pulses produced by the button/coin edge-detector stage. It tracks inserted credit, product selection and per-product stock, and sequences dispense and change return. Its outputs drive the display and actuator logic downstream.

Parameters:
PRICE0, 3, price of product 0 in credit units
PRICE1, 5, price of product 1
PRICE2, 8, price of product 2
PRICE3, 10, price of product 3
MAX_CREDIT, 99, credit ceiling (must fit in 8 bits)
STOCK_INIT, 5, per-product stock after reset or restock (4-bit, 0..15)
HOLD_CYCLES, 1000, cycles that dispense or change_valid stays high (≥1)
TIMEOUT, 1000000, idle cycles in CREDIT before automatic refund (≥1, counter 21 bits)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
coin1_p  in  1  one-cycle pulse: 1-unit coin inserted
coin5_p  in  1  one-cycle pulse: 5-unit coin
coin10_p  in  1  one-cycle pulse: 10-unit coin
sel_p  in  1  one-cycle pulse: advance selection 0→1→2→3→0
buy_p  in  1  one-cycle pulse: purchase selected product
cancel_p  in  1  one-cycle pulse: abort and refund
restock_p  in  1  one-cycle pulse: reload all stock to STOCK_INIT
credit  out  8  current credit
sel_idx  out  2  current selection
price  out  8  price of sel_idx (combinational mux)
sold_out  out  1  stock[sel_idx]==0 (combinational)
dispense  out  1  high during VEND
disp_idx  out  2  product being dispensed, stable during VEND
change_valid  out  1  high during REFUND
change_amt  out  8  amount returned, stable during REFUND
coin_reject  out  1  one-cycle pulse: coin(s) returned
buy_fail  out  1  one-cycle pulse: buy refused
busy  out  1  state is VEND or REFUND

Behaviour:
- Reset (async, any state): state=IDLE; credit=0; sel_idx=0; all stock=STOCK_INIT; timer=0. dispense, change_valid, coin_reject and buy_fail are 0. disp_idx=0; change_amt=0.
- States: IDLE (credit==0), CREDIT, VEND, REFUND.
- All inputs are registered-domain pulses. Response is visible on the cycle after the pulse; no extra latency.
- Same-cycle priority in IDLE/CREDIT: cancel_p > buy_p > coins > sel_p. Lower-priority pulses in that cycle are dropped. A dropped coin asserts coin_reject.
- Exception: restock_p is acted on only in IDLE and only when no other pulse is present that cycle. Otherwise it is ignored.
- Coins: sum = 1·coin1_p + 5·coin5_p + 10·coin10_p, summed over all asserted coin pulses.
  - If credit+sum ≤ MAX_CREDIT, credit += sum, and IDLE moves to CREDIT.
  - Otherwise credit is unchanged and coin_reject pulses. All coins in that cycle are rejected.
- sel_p: sel_idx increments mod 4 in IDLE/CREDIT. It is ignored in VEND/REFUND.
- buy_p in CREDIT:
  - If sold_out, or credit < price: buy_fail pulses and state is unchanged.
  - Otherwise: stock[sel_idx] decrements; disp_idx=sel_idx; credit -= price; go to VEND.
- buy_p in IDLE: buy_fail pulses.
- cancel_p in CREDIT: change_amt=credit; credit=0; go to REFUND. In IDLE it is a no-op.
- Timeout: in CREDIT the timer counts every cycle with no input pulse and clears on any pulse. When timer reaches TIMEOUT-1, the same action as cancel occurs.
- VEND: dispense=1 for exactly HOLD_CYCLES cycles. At the end:
  - if credit>0: change_amt=credit, credit=0, go to REFUND;
  - else go to IDLE.
- REFUND: change_valid=1 for exactly HOLD_CYCLES cycles. Then change_amt=0 and go to IDLE.
- In VEND/REFUND:
  - any coin pulse is rejected (coin_reject);
  - buy_p pulses buy_fail;
  - cancel_p, sel_p and restock_p are ignored.
- Stock never underflows: buy is refused when it is 0.
- Credit never exceeds MAX_CREDIT. All arithmetic is 8-bit unsigned with no wrap.

Test Plan:
Use HOLD_CYCLES=4 and TIMEOUT=20 for all scenarios.
1. Reset, coin5_p, coin5_p, buy_p (sel 1, price 5) → credit 10. dispense high 4 cycles with disp_idx=1. Then change_valid high 4 cycles with change_amt=5. Ends in IDLE with credit 0 and stock1=4.
2. coin10_p ×9 then coin10_p → credit 90. 10th coin gives coin_reject=1 with credit still 90. Then coin1_p ×9 → 99. Further coin1_p → coin_reject.
3. coin1_p ×3, sel_p ×2 (price 8), buy_p → buy_fail pulse, credit stays 3. cancel_p → REFUND with change_amt=3 for 4 cycles, then IDLE.
4. Buy product 0 five times with exact 3 credit each → stock0=0, sold_out=1. Sixth buy → buy_fail. restock_p in IDLE → sold_out=0.
5. coin5_p then no pulses → after 20 cycles REFUND with change_amt=5. A coin1_p during REFUND → coin_reject, credit stays 0.
6. buy_p and cancel_p in the same cycle with credit 10 → cancel wins: change_amt=10, no dispense. Assert rst_n low mid-VEND → all outputs return to reset values immediately and stock is reloaded.
